l1_pte_responder: RTL and testbench



---
 rtl/l1_resp_pkg.sv | 20 ++
 rtl/sat_cnt16.sv | 37 +++
 rtl/l1_pte_responder.sv | 144 ++++++++++++++
 tb/tb_l1_pte_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_resp_pkg.sv
// ----------------------------------------------------------------------------
// l1_resp_pkg
// Shared constants and types for the L1 PTE responder.
//   FAULT_WORD     : word returned for faulting PTE loads (bits [31:12] set)
//   VA_W / PA_W    : request address width / returned word width
//   l1_resp_slot_t : one response pipeline slot {vld, data}
// ----------------------------------------------------------------------------
package l1_resp_pkg;

   localparam int unsigned VA_W = 28;
   localparam int unsigned PA_W = 32;

   localparam logic [PA_W-1:0] FAULT_WORD = 32'hFFFF_F000;

   typedef struct packed {
      logic            vld;
      logic [PA_W-1:0] data;
   } l1_resp_slot_t;

endpackage : l1_resp_pkg

// File: rtl/sat_cnt16.sv
// ----------------------------------------------------------------------------
// sat_cnt16
// 16-bit up counter that sticks at 16'hFFFF instead of wrapping.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   inc_i   : add one on this edge (ignored once saturated)
//   cnt_o   : current count
// ----------------------------------------------------------------------------
module sat_cnt16 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_cnt16

// File: rtl/l1_pte_responder.sv
// ----------------------------------------------------------------------------
// l1_pte_responder
// Responder end of the page-table walker's L1 interface. Looks up 32-bit PTE
// words in a local, writable PTE store and returns them LAT cycles after the
// request, with an optional one-cycle-late cancel.
//
// Handshake: there is no ready. A request is taken on any rising edge with
// l1_va_vld_i=1 and stall_i=0; a request offered while stalled is lost. Each
// taken request produces exactly one l1_vld_o cycle, in order, unless it is
// cancelled by l1_cancel_i on the edge after it was taken.
//
// Parameters:
//   LAT    : request-to-response latency in cycles (2..4)
//   ADDR_W : PTE store index width, DEPTH = 2**ADDR_W words
// Ports:
//   clk_i, resetn_i : clock, asynchronous active-low reset
//   l1_va_i         : word-aligned byte address of the PTE
//   l1_va_vld_i     : request valid
//   l1_cancel_i     : kill the request taken on the previous edge
//   l1_pa_o         : returned PTE word
//   l1_vld_o        : response valid
//   stall_i         : freeze the pipeline and refuse new requests
//   cfg_we_i        : PTE store write enable
//   cfg_addr_i      : PTE store write index
//   cfg_wdata_i     : PTE store write data
//   req_cnt_o       : accepted request count, saturating
//   cancel_cnt_o    : effective cancel count, saturating
// ----------------------------------------------------------------------------
module l1_pte_responder
   import l1_resp_pkg::*;
#(
   parameter int unsigned LAT    = 2,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic [VA_W-1:0]   l1_va_i,
   input  logic              l1_va_vld_i,
   input  logic              l1_cancel_i,
   output logic [PA_W-1:0]   l1_pa_o,
   output logic              l1_vld_o,
   input  logic              stall_i,
   input  logic              cfg_we_i,
   input  logic [ADDR_W-1:0] cfg_addr_i,
   input  logic [PA_W-1:0]   cfg_wdata_i,
   output logic [15:0]       req_cnt_o,
   output logic [15:0]       cancel_cnt_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [PA_W-1:0] store_q [DEPTH];

   l1_resp_slot_t pipe_q [LAT];
   l1_resp_slot_t pipe_d [LAT];

   logic              accept;
   logic              cancel_hit;
   logic              is_fault;
   logic [ADDR_W-1:0] lookup_idx;
   logic [PA_W-1:0]   lookup_data;

   // ------------------------------------------------------------------------
   // Request decode and store lookup
   // ------------------------------------------------------------------------
   assign accept     = l1_va_vld_i & ~stall_i;
   assign lookup_idx = l1_va_i[ADDR_W+1:2];

   // Anything above the store window or not word aligned is a fault.
   assign is_fault = (l1_va_i[VA_W-1:ADDR_W+2] != '0) || (l1_va_i[1:0] != 2'b00);

   // The store is read before this edge's write lands, so a same-edge write to
   // the looked-up index is seen only by later requests.
   assign lookup_data = is_fault ? FAULT_WORD : store_q[lookup_idx];

   // A cancel only counts when it actually kills a live stage-1 slot.
   assign cancel_hit = l1_cancel_i & pipe_q[0].vld;

   // ------------------------------------------------------------------------
   // Response pipeline
   // ------------------------------------------------------------------------
   always_comb begin
      pipe_d = pipe_q;
      if (stall_i) begin
         // Frozen, but a cancel still reaches the held stage-1 slot.
         pipe_d[0].vld = pipe_q[0].vld & ~l1_cancel_i;
      end else begin
         // Stage 1 takes the new request; the cancel applies to the slot
         // leaving stage 1, never to the one entering it.
         pipe_d[0].vld  = accept;
         pipe_d[0].data = lookup_data;
         pipe_d[1].vld  = pipe_q[0].vld & ~l1_cancel_i;
         pipe_d[1].data = pipe_q[0].data;
         for (int k = 2; k < LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int k = 0; k < LAT; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   // The last stage is the registered response.
   assign l1_vld_o = pipe_q[LAT-1].vld;
   assign l1_pa_o  = pipe_q[LAT-1].data;

   // ------------------------------------------------------------------------
   // PTE store
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            store_q[i] <= '0;
         end
      end else if (cfg_we_i) begin
         store_q[cfg_addr_i] <= cfg_wdata_i;
      end
   end

   // ------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------
   sat_cnt16 u_req_cnt (
      .clk_i  (clk_i),
      .rst_ni (resetn_i),
      .inc_i  (accept),
      .cnt_o  (req_cnt_o)
   );

   sat_cnt16 u_cancel_cnt (
      .clk_i  (clk_i),
      .rst_ni (resetn_i),
      .inc_i  (cancel_hit),
      .cnt_o  (cancel_cnt_o)
   );

endmodule : l1_pte_responder

// File: tb/tb_l1_pte_responder.sv
// ----------------------------------------------------------------------------
// tb_l1_pte_responder
// Self-checking bench for l1_pte_responder (LAT=2, ADDR_W=6).
// Expected responses are pushed as {due_cycle, data} when a request is driven
// and popped by the response monitor; scenario tasks check counters inline.
// ----------------------------------------------------------------------------
module tb_l1_pte_responder;

   localparam int unsigned LAT    = 2;
   localparam int unsigned ADDR_W = 6;

   // -------------------------------------------------------------------------
   // Clock / reset
   // -------------------------------------------------------------------------
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic              resetn_i;
   logic [27:0]       l1_va_i;
   logic              l1_va_vld_i;
   logic              l1_cancel_i;
   logic [31:0]       l1_pa_o;
   logic              l1_vld_o;
   logic              stall_i;
   logic              cfg_we_i;
   logic [ADDR_W-1:0] cfg_addr_i;
   logic [31:0]       cfg_wdata_i;
   logic [15:0]       req_cnt_o;
   logic [15:0]       cancel_cnt_o;

   l1_pte_responder #(.LAT(LAT), .ADDR_W(ADDR_W)) dut (
      .clk_i        (clk_i),
      .resetn_i     (resetn_i),
      .l1_va_i      (l1_va_i),
      .l1_va_vld_i  (l1_va_vld_i),
      .l1_cancel_i  (l1_cancel_i),
      .l1_pa_o      (l1_pa_o),
      .l1_vld_o     (l1_vld_o),
      .stall_i      (stall_i),
      .cfg_we_i     (cfg_we_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .req_cnt_o    (req_cnt_o),
      .cancel_cnt_o (cancel_cnt_o)
   );

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc++;

   // -------------------------------------------------------------------------
   // Scoreboard state
   // -------------------------------------------------------------------------
   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [31:0] mem_m [64];
   int unsigned req_m    = 0;
   int unsigned can_m    = 0;
   logic [63:0] mon_e;

   function automatic logic [31:0] exp_lookup(input logic [27:0] va);
      logic [5:0] idx;
      idx = va[7:2];
      if ((va[27:8] != 20'd0) || (va[1:0] != 2'b00)) return 32'hFFFF_F000;
      return mem_m[idx];
   endfunction

   // Response monitor: every l1_vld_o cycle must match the queue head, and a
   // head whose due cycle has passed without a response is a miss.
   always @(negedge clk_i) begin
      if (resetn_i) begin
         if (l1_vld_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_resp cyc=%0d got=%h required=none", cyc, l1_pa_o);
            end else begin
               mon_e = exp_q.pop_front();
               if ((mon_e[63:32] !== cyc) || (mon_e[31:0] !== l1_pa_o)) begin
                  failures++;
                  $display("FAIL resp cyc=%0d data=%h required cyc=%0d data=%h",
                           cyc, l1_pa_o, mon_e[63:32], mon_e[31:0]);
               end
            end
         end else if ((exp_q.size() != 0) && (exp_q[0][63:32] <= cyc)) begin
            checks++;
            failures++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_resp cyc=%0d got=none required cyc=%0d data=%h",
                     cyc, mon_e[63:32], mon_e[31:0]);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Driver tasks
   // -------------------------------------------------------------------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
      cfg_we_i    = 1'b1;
      cfg_addr_i  = a;
      cfg_wdata_i = d;
      step();
      mem_m[a] = d;
      cfg_we_i = 1'b0;
   endtask

   // Present one unstalled request for one cycle (extra_lat = known stall cycles).
   task automatic drive_req(input logic [27:0] va, input int unsigned extra_lat);
      l1_va_i     = va;
      l1_va_vld_i = 1'b1;
      exp_q.push_back({32'(cyc + LAT + extra_lat), exp_lookup(va)});
      if (req_m < 32'hFFFF) req_m++;
      step();
      l1_va_vld_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < 20)) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      step();
   endtask

   task automatic check_counters(input string tag);
      checks++;
      if (req_cnt_o !== 16'(req_m)) begin
         failures++;
         $display("FAIL %s_req_cnt got=%0d required=%0d", tag, req_cnt_o, req_m);
      end
      checks++;
      if (cancel_cnt_o !== 16'(can_m)) begin
         failures++;
         $display("FAIL %s_cancel_cnt got=%0d required=%0d", tag, cancel_cnt_o, can_m);
      end
   endtask

   // -------------------------------------------------------------------------
   // Scenarios
   // -------------------------------------------------------------------------
   task automatic test_reset();
      checks++;
      if (l1_vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b required=0", l1_vld_o); end
      checks++;
      if (l1_pa_o !== 32'd0) begin failures++; $display("FAIL reset_pa got=%h required=0", l1_pa_o); end
      check_counters("reset");
   endtask

   task automatic test_single();
      cfg_write(6'd5, 32'h0000_0ABC);
      drive_req(28'h14, 0);
      drain();
      check_counters("single");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) cfg_write(6'(i), 32'(i + 1));
      for (int i = 0; i < 4; i++) drive_req(28'(i * 4), 0);
      drain();
      // A few random in-range and faulting addresses, back to back.
      for (int i = 0; i < 6; i++) drive_req(28'($urandom_range(0, 63) * 4), 0);
      drive_req(28'h0000_100, 0);
      drive_req(28'h0000_006, 0);
      drain();
      check_counters("b2b");
   endtask

   task automatic test_fault();
      drive_req(28'h0000_100, 0);
      drive_req(28'h0000_006, 0);
      drive_req(28'hFFF_FFFC, 0);
      drain();
   endtask

   task automatic test_cancel();
      cfg_write(6'd10, 32'h1234_5678);
      // Killed request: no pulse.
      drive_req(28'h28, 0);
      l1_cancel_i = 1'b1;
      void'(exp_q.pop_back());
      can_m++;
      step();
      l1_cancel_i = 1'b0;
      drain();
      check_counters("cancel");
      // Cancel with nothing in stage 1 is ignored.
      repeat (3) step();
      l1_cancel_i = 1'b1;
      step();
      l1_cancel_i = 1'b0;
      step();
      check_counters("cancel_idle");
      // Cancel alongside a new request kills only the older one.
      drive_req(28'h28, 0);
      void'(exp_q.pop_back());
      can_m++;
      l1_cancel_i = 1'b1;
      drive_req(28'h0C, 0);
      l1_cancel_i = 1'b0;
      drain();
      check_counters("cancel_same_edge");
      // Cancel honoured while stalled.
      drive_req(28'h28, 0);
      void'(exp_q.pop_back());
      can_m++;
      stall_i     = 1'b1;
      l1_cancel_i = 1'b1;
      step();
      l1_cancel_i = 1'b0;
      step();
      stall_i = 1'b0;
      drain();
      check_counters("cancel_stall");
   endtask

   task automatic test_stall();
      cfg_write(6'd9, 32'h0000_0099);
      drive_req(28'h24, 3);
      stall_i = 1'b1;
      step();
      l1_va_i     = 28'h10;
      l1_va_vld_i = 1'b1;
      step();
      l1_va_vld_i = 1'b0;
      step();
      stall_i = 1'b0;
      check_counters("stall");
      drain();
   endtask

   task automatic test_same_edge_write();
      logic [31:0] old_v;
      cfg_write(6'd7, 32'h0000_0007);
      old_v = mem_m[7];
      cfg_we_i    = 1'b1;
      cfg_addr_i  = 6'd7;
      cfg_wdata_i = 32'hCAFE_0777;
      drive_req(28'h1C, 0);
      cfg_we_i = 1'b0;
      mem_m[7] = 32'hCAFE_0777;
      drive_req(28'h1C, 0);
      checks++;
      if (exp_q[0][31:0] === exp_q[1][31:0]) begin
         failures++;
         $display("FAIL same_edge_model old=%h new=%h required differ", old_v, mem_m[7]);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      drive_req(28'h1C, 0);
      drive_req(28'h14, 0);
      resetn_i = 1'b0;
      #1;
      exp_q.delete();
      for (int i = 0; i < 64; i++) mem_m[i] = '0;
      req_m = 0;
      can_m = 0;
      checks++;
      if (l1_vld_o !== 1'b0) begin failures++; $display("FAIL rst_mid_vld got=%b required=0", l1_vld_o); end
      check_counters("rst_mid");
      step();
      step();
      resetn_i = 1'b1;
      repeat (5) step();
      drive_req(28'h14, 0);
      drive_req(28'h1C, 0);
      drain();
      check_counters("rst_after");
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 65540; i++) drive_req(28'h0, 0);
      drain();
      checks++;
      if (req_cnt_o !== 16'hFFFF) begin
         failures++;
         $display("FAIL req_saturate got=%h required=ffff", req_cnt_o);
      end
      check_counters("saturate");
   endtask

   // -------------------------------------------------------------------------
   // Sequence and report
   // -------------------------------------------------------------------------
   initial begin
      resetn_i    = 1'b0;
      l1_va_i     = '0;
      l1_va_vld_i = 1'b0;
      l1_cancel_i = 1'b0;
      stall_i     = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_addr_i  = '0;
      cfg_wdata_i = '0;
      for (int i = 0; i < 64; i++) mem_m[i] = '0;
      #2;
      step();
      test_reset();
      step();
      resetn_i = 1'b1;
      step();

      test_single();
      test_back_to_back();
      test_fault();
      test_cancel();
      test_stall();
      test_same_edge_write();
      test_reset_mid();
      test_saturate();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_l1_pte_responder
